tick_mod_cnt: RTL and testbench
===============================

Name: tick_mod_cnt

Overview:
- Parametrised successor to the fixed 0..59 counter driven by a divided clock.
- Single clock domain. An internal divider produces a one-cycle tick enable instead of a derived clock.
- A modulo-MOD up/down counter advances on each tick and supports load, clear and wrap carry.
- Instances chain via carry to build sec/min/hour time bases on the 50 MHz system clock.

Parameters:
- WIDTH, 6: counter width in bits.
- MOD, 60: counter modulus. Count range 0..MOD-1. Requires 2 <= MOD <= 2^WIDTH.
- DIV_W, 32: width of the divider count and of num.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- num  in  DIV_W  clk cycles per tick. Values 0 and 1 both mean a tick every enabled cycle.
- en  in  1  global enable. Low freezes the divider and the counter.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  WIDTH  load value.
- out  out  WIDTH  current count.
- tick  out  1  registered one-cycle pulse, high in the cycle after a divider terminal count.
- carry  out  1  registered one-cycle pulse on wrap (up: MOD-1->0; down: 0->MOD-1).

Behaviour:
- Reset (rst_n low, asynchronous): divider cnt=0, out=0, tick=0, carry=0. Release is synchronous to the next clk edge.
- Divider:
  - cnt counts 0..N-1, where N = max(num,1).
  - Terminal count tc = en & (cnt >= N-1). The comparison is >= so a runtime decrease of num below cnt wraps at the next enabled edge instead of running to 2^DIV_W.
  - On tc: cnt<=0. Otherwise, if en: cnt<=cnt+1.
  - en low: cnt holds and tc=0.
- tick <= tc every edge, so it is high exactly one cycle per terminal count.
- Counter update priority, evaluated per edge:
  1. clr: out<=0, divider cnt<=0, carry<=0. tick still follows tc.
  2. load: out<=min(load_val, MOD-1), carry<=0. Divider unaffected. A tc in the same cycle is consumed with no count step.
  3. tc & up_dn: if out >= MOD-1 then out<=0 and carry<=1, else out<=out+1 and carry<=0.
  4. tc & ~up_dn: if out==0 or out > MOD-1 then out<=MOD-1 and carry<=(out==0), else out<=out-1 and carry<=0.
  5. Otherwise: out holds, carry<=0.
- Latency: tc sampled at edge k. New out, tick and carry are all visible together after edge k.
- The out >= MOD-1 guard in step 3 forces any illegal value back to 0 on the next up tick. No other path can produce an illegal value.
- up_dn changes take effect on the next tick. There is no glitch on carry.
- Arithmetic is unsigned, WIDTH bits. load_val is clamped before the register.
- Mid-operation reset: all state returns to reset values immediately, regardless of clk.

Optional Feature:
- Macro: TICK_MOD_CNT_BCD_EN.
- Defined:
  - Adds output out_bcd[7:0] = {tens, ones} of out, registered, updating in the same cycle as out.
  - Elaboration error if MOD > 100.
  - Reset value 8'h00.
- Undefined: port and logic absent. Behaviour otherwise identical.

Decomposition:
- Package cnt_pkg holds:
  - DIV_W_DEF=32.
  - CLK_HZ=50_000_000.
  - Standard moduli SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24.
  - A function for the clamp value.
- Sub-module tick_gen (parameter DIV_W; ports clk, rst_n, en, sclr, num, tc) contains the divider. tick_mod_cnt instantiates one tick_gen.

Test Plan:
1. Reset, num=4, en=1, up_dn=1 -> tick every 4th cycle; out 0,1,2..59,0 with carry high only on the 59->0 step; 240 cycles give exactly one carry.
2. num=0 and num=1, MOD=60 -> tick every cycle; out increments each cycle; carry on the 60th tick.
3. up_dn=0 from out=0, num=2 -> first tick gives out=59 and carry=1; then 58, 57 with carry=0.
4. load=1, load_val=63 (MOD=60) -> out=59. load with tc in the same cycle -> no step. clr together with load -> out=0 and divider restarts (next tick after num cycles).
5. num changed 1000->3 while cnt=500 -> tc on the next enabled edge, then period 3. en low for 10 cycles -> out, cnt and tick frozen, resuming exactly where they stopped.
6. Assert rst_n low asynchronously mid-count (out=37) -> out=0, tick=0, carry=0 immediately. With TICK_MOD_CNT_BCD_EN, out=47 -> out_bcd=8'h47.

Source files
------------

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants and helpers for the tick_mod_cnt family.
//   DIV_W_DEF            default width of the tick divider and its period input
//   CLK_HZ               system clock frequency used to derive tick periods
//   SEC_MOD/MIN_MOD/HOUR_MOD  standard moduli for chained time bases
//   clamp_val()          saturates a load value to the top of the count range
package cnt_pkg;

  localparam int DIV_W_DEF = 32;
  localparam int CLK_HZ    = 50_000_000;
  localparam int SEC_MOD   = 60;
  localparam int MIN_MOD   = 60;
  localparam int HOUR_MOD  = 24;

  // Largest legal count for a modulus is modulus-1; anything above saturates there.
  function automatic int unsigned clamp_val(input int unsigned val,
                                            input int unsigned modulus);
    return (val > modulus - 1) ? modulus - 1 : val;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: programmable divider producing a combinational terminal-count enable.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   en     enable; low freezes the divider and suppresses tc
//   sclr   synchronous clear of the divider count
//   num    cycles per terminal count (0 and 1 both give a tc every enabled cycle)
//   tc     terminal count, high for one enabled cycle per period
module tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sclr,
  input  logic [DIV_W-1:0] num,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  always_comb begin
    last_cnt = (num == '0) ? '0 : num - DIV_W'(1);
    // >= rather than == so shrinking num below the running count wraps
    // immediately instead of running all the way around the counter.
    tc    = en && (cnt_q >= last_cnt);
    cnt_d = cnt_q;
    if (sclr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_mod_cnt.sv
// tick_mod_cnt: modulo-MOD up/down counter advanced by an internal tick divider.
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   num       clk cycles per tick
//   en        global enable (freezes divider and counter when low)
//   up_dn     1 = count up, 0 = count down
//   clr       synchronous clear of count, carry and divider
//   load      synchronous load of load_val (clamped to MOD-1)
//   load_val  value to load
//   out       current count, 0..MOD-1
//   tick      registered pulse one cycle after each divider terminal count
//   carry     registered pulse on wrap (up MOD-1->0, down 0->MOD-1)
//   out_bcd   {tens, ones} of out; present only when TICK_MOD_CNT_BCD_EN is defined
module tick_mod_cnt
  import cnt_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MOD   = 60,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] num,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             carry
`ifdef TICK_MOD_CNT_BCD_EN
  ,
  output logic [7:0]       out_bcd
`endif
);

  if ((MOD < 2) || (64'(MOD) > (64'(1) << WIDTH))) begin : g_mod_range_err
    $error("tick_mod_cnt: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic             tc;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q;
  logic             carry_q, carry_d;

  tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .sclr (clr),
    .num  (num),
    .tc   (tc)
  );

  always_comb begin
    out_d   = out_q;
    carry_d = 1'b0;
    if (clr) begin
      out_d = '0;
    end else if (load) begin
      // A coincident tc is swallowed by the load: no count step this cycle.
      out_d = WIDTH'(clamp_val(32'(load_val), MOD));
    end else if (tc) begin
      if (up_dn) begin
        // >= also steers any out-of-range value back to 0.
        if (out_q >= MAX_VAL) begin
          out_d   = '0;
          carry_d = 1'b1;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          out_d   = MAX_VAL;
          carry_d = 1'b1;
        end else if (out_q > MAX_VAL) begin
          out_d = MAX_VAL;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      tick_q  <= tc;
      carry_q <= carry_d;
    end
  end

  assign out   = out_q;
  assign tick  = tick_q;
  assign carry = carry_q;

`ifdef TICK_MOD_CNT_BCD_EN
  if (MOD > 100) begin : g_bcd_mod_err
    $error("tick_mod_cnt: BCD output requires MOD <= 100");
  end

  logic [7:0] bin_d;
  logic [7:0] bcd_d;
  logic [7:0] bcd_q;

  // Derived from out_d so the BCD view changes on the same edge as out.
  always_comb begin
    bin_d = 8'(out_d);
    bcd_d = {4'(bin_d / 8'd10), 4'(bin_d % 8'd10)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= 8'h00;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign out_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_tick_mod_cnt.sv
module tb_tick_mod_cnt;

  localparam int WIDTH = 6;
  localparam int MOD   = 60;
  localparam int DIV_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] num;
  logic             en, up_dn, clr, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tick, carry;
`ifdef TICK_MOD_CNT_BCD_EN
  logic [7:0]       out_bcd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, advanced once per driven cycle.
  logic [DIV_W-1:0] m_cnt;
  logic [WIDTH-1:0] m_out;

  // Expected {out, tick, carry} after each edge.
  logic [WIDTH+1:0] exp_q[$];

  always #5 clk = ~clk;

  tick_mod_cnt #(
    .WIDTH(WIDTH),
    .MOD  (MOD),
    .DIV_W(DIV_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .num     (num),
    .en      (en),
    .up_dn   (up_dn),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .tick    (tick),
    .carry   (carry)
`ifdef TICK_MOD_CNT_BCD_EN
    ,
    .out_bcd (out_bcd)
`endif
  );

  // Scoreboard: pop one expectation per edge and compare just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if ({out, tick, carry} !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t out=%0d tick=%0b carry=%0b required out=%0d tick=%0b carry=%0b",
                   $time, out, tick, carry, e[WIDTH+1:2], e[1], e[0]);
        end
      end
    end
  end

  // Drive one cycle from a negedge, predict the post-edge outputs, wait for the next negedge.
  task automatic drive_cycle(input logic c_en, input logic c_up, input logic c_clr,
                             input logic c_load, input logic [WIDTH-1:0] c_lv,
                             input logic [DIV_W-1:0] c_num);
    logic [DIV_W-1:0] period_last;
    logic             e_tc, e_carry;
    logic [WIDTH-1:0] e_out;
    en = c_en; up_dn = c_up; clr = c_clr; load = c_load; load_val = c_lv; num = c_num;
    period_last = (c_num == 0) ? '0 : c_num - 1;
    e_tc    = c_en && (m_cnt >= period_last);
    e_out   = m_out;
    e_carry = 1'b0;
    if (c_clr) begin
      e_out = 0;
    end else if (c_load) begin
      e_out = (c_lv > MOD - 1) ? WIDTH'(MOD - 1) : c_lv;
    end else if (e_tc && c_up) begin
      if (m_out == MOD - 1) begin e_out = 0; e_carry = 1'b1; end
      else e_out = m_out + 1;
    end else if (e_tc) begin
      if (m_out == 0) begin e_out = WIDTH'(MOD - 1); e_carry = 1'b1; end
      else e_out = m_out - 1;
    end
    if (c_clr || e_tc) m_cnt = 0;
    else if (c_en) m_cnt = m_cnt + 1;
    m_out = e_out;
    exp_q.push_back({e_out, e_tc, e_carry});
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; num = 4; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 0;
    m_cnt = 0; m_out = 0;
    #3;
    n_checks++;
    if (out !== 0) begin n_fail++; $display("FAIL reset_out out=%0d required 0", out); end
    n_checks++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick tick=%0b required 0", tick); end
    n_checks++;
    if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry carry=%0b required 0", carry); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_up_count;
    int carries = 0;
    for (int i = 0; i < 240; i++) begin
      drive_cycle(1, 1, 0, 0, 0, 4);
      if (carry) carries++;
    end
    n_checks++;
    if (carries != 1) begin n_fail++; $display("FAIL up_240_carries count=%0d required 1", carries); end
    n_checks++;
    if (out !== 0) begin n_fail++; $display("FAIL up_240_out out=%0d required 0", out); end
    $display("test_up_count done carries=%0d", carries);
  endtask

  task automatic test_fast_tick;
    for (int k = 0; k < 2; k++) begin
      int carries = 0;
      drive_cycle(1, 1, 1, 0, 0, DIV_W'(k));
      for (int i = 1; i <= 60; i++) begin
        drive_cycle(1, 1, 0, 0, 0, DIV_W'(k));
        if (carry) carries++;
        if (i == 59) begin
          n_checks++;
          if (out !== 59) begin n_fail++; $display("FAIL fast_num%0d_out59 out=%0d required 59", k, out); end
        end
      end
      n_checks++;
      if (carries != 1 || carry !== 1'b1) begin
        n_fail++;
        $display("FAIL fast_num%0d_carry carries=%0d last=%0b required 1 and 1", k, carries, carry);
      end
      $display("test_fast_tick num=%0d done", k);
    end
  endtask

  task automatic test_down;
    drive_cycle(1, 0, 1, 0, 0, 2);
    drive_cycle(1, 0, 0, 0, 0, 2);
    drive_cycle(1, 0, 0, 0, 0, 2);
    n_checks++;
    if (out !== 59 || carry !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap out=%0d carry=%0b required 59 1", out, carry);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 2);
      drive_cycle(1, 0, 0, 0, 0, 2);
      n_checks++;
      if (out !== WIDTH'(58 - i) || carry !== 1'b0) begin
        n_fail++; $display("FAIL down_step%0d out=%0d carry=%0b required %0d 0", i, out, carry, 58 - i);
      end
    end
    $display("test_down done");
  endtask

  task automatic test_load_clr;
    drive_cycle(1, 1, 0, 1, 63, 1000);
    n_checks++;
    if (out !== 59) begin n_fail++; $display("FAIL load_clamp out=%0d required 59", out); end
    // num=1: every cycle is a tc, so the load cycle must not step.
    drive_cycle(1, 1, 0, 1, 10, 1);
    n_checks++;
    if (out !== 10 || tick !== 1'b1) begin
      n_fail++; $display("FAIL load_with_tc out=%0d tick=%0b required 10 1", out, tick);
    end
    drive_cycle(1, 1, 0, 0, 0, 1);
    n_checks++;
    if (out !== 11) begin n_fail++; $display("FAIL load_then_step out=%0d required 11", out); end
    drive_cycle(1, 1, 1, 1, 20, 4);
    n_checks++;
    if (out !== 0) begin n_fail++; $display("FAIL clr_over_load out=%0d required 0", out); end
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1, 1, 0, 0, 0, 4);
      n_checks++;
      if (tick !== (i == 4) || out !== WIDTH'(i == 4)) begin
        n_fail++; $display("FAIL clr_restart_c%0d tick=%0b out=%0d required %0b %0d", i, tick, out, i == 4, i == 4);
      end
    end
    $display("test_load_clr done");
  endtask

  task automatic test_num_change_en;
    logic [WIDTH-1:0] held;
    drive_cycle(1, 1, 1, 0, 0, 1000);
    for (int i = 0; i < 500; i++) drive_cycle(1, 1, 0, 0, 0, 1000);
    drive_cycle(1, 1, 0, 0, 0, 3);
    n_checks++;
    if (tick !== 1'b1 || out !== 1) begin
      n_fail++; $display("FAIL num_shrink tick=%0b out=%0d required 1 1", tick, out);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 0, 0, 3);
    held = out;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 1, 0, 0, 0, 3);
      n_checks++;
      if (out !== held || tick !== 1'b0) begin
        n_fail++; $display("FAIL en_freeze_c%0d out=%0d tick=%0b required %0d 0", i, out, tick, held);
      end
    end
    for (int i = 0; i < 9; i++) drive_cycle(1, 1, 0, 0, 0, 3);
    $display("test_num_change_en done out=%0d", out);
  endtask

  task automatic test_async_reset;
    drive_cycle(1, 1, 0, 1, 37, 1);
    n_checks++;
    if (out !== 37) begin n_fail++; $display("FAIL preload37 out=%0d required 37", out); end
    drive_cycle(1, 1, 0, 0, 0, 1);
`ifdef TICK_MOD_CNT_BCD_EN
    drive_cycle(1, 1, 0, 1, 47, 1);
    n_checks++;
    if (out_bcd !== 8'h47) begin n_fail++; $display("FAIL bcd47 out_bcd=%h required 47", out_bcd); end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 0 || tick !== 1'b0 || carry !== 1'b0) begin
      n_fail++; $display("FAIL async_reset out=%0d tick=%0b carry=%0b required 0 0 0", out, tick, carry);
    end
`ifdef TICK_MOD_CNT_BCD_EN
    n_checks++;
    if (out_bcd !== 8'h00) begin n_fail++; $display("FAIL bcd_reset out_bcd=%h required 00", out_bcd); end
`endif
    m_cnt = 0; m_out = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0, 0, 2);
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_fast_tick();
    test_down();
    test_load_clr();
    test_num_change_en();
    test_async_reset();
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
